btb_2bit_predictor: RTL and testbench

BTB_2BIT_PREDICTOR -- requirements
Module: btb_2bit_predictor

---
 rtl/btb_2bit_predictor.sv | 126 ++++++++++++
 tb/tb_btb_2bit_predictor.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/btb_2bit_predictor.sv
// Fully associative branch target buffer with 2-bit saturating direction counters.
// Lookup is combinational from registered state; updates land on the next rising edge.
module btb_2bit_predictor #(
   parameter int unsigned ENTRIES  = 8,
   parameter int unsigned XLEN     = 32,
   parameter logic [1:0]  CTR_INIT = 2'b10
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic [XLEN-1:0] lookup_pc,
   output logic            pred_hit,
   output logic            pred_taken,
   output logic [XLEN-1:0] pred_target,
   input  logic            upd_valid,
   input  logic [XLEN-1:0] upd_pc,
   input  logic            upd_taken,
   input  logic [XLEN-1:0] upd_target,
   input  logic            flush
);

   localparam int unsigned IDXW = $clog2(ENTRIES);

   logic            valid_q  [ENTRIES];
   logic            valid_d  [ENTRIES];
   logic [XLEN-1:0] tag_q    [ENTRIES];
   logic [XLEN-1:0] tag_d    [ENTRIES];
   logic [XLEN-1:0] tgt_q    [ENTRIES];
   logic [XLEN-1:0] tgt_d    [ENTRIES];
   logic [1:0]      ctr_q    [ENTRIES];
   logic [1:0]      ctr_d    [ENTRIES];
   logic [IDXW-1:0] victim_q;
   logic [IDXW-1:0] victim_d;

   logic            look_hit;
   logic [1:0]      look_ctr;
   logic [XLEN-1:0] look_tgt;

   logic            upd_hit;
   logic [IDXW-1:0] upd_idx;
   logic            free_found;
   logic [IDXW-1:0] free_idx;
   logic [IDXW-1:0] alloc_idx;

   // At most one entry can match, so the first match found is the only one.
   always_comb begin
      look_hit = 1'b0;
      look_ctr = '0;
      look_tgt = '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
         if (valid_q[i] && tag_q[i] == lookup_pc) begin
            look_hit = 1'b1;
            look_ctr = ctr_q[i];
            look_tgt = tgt_q[i];
         end
      end
   end

   assign pred_hit    = look_hit;
   assign pred_taken  = look_hit & look_ctr[1];
   assign pred_target = pred_taken ? look_tgt : lookup_pc + XLEN'(4);

   always_comb begin
      upd_hit    = 1'b0;
      upd_idx    = '0;
      free_found = 1'b0;
      free_idx   = '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
         if (valid_q[i] && tag_q[i] == upd_pc) begin
            upd_hit = 1'b1;
            upd_idx = IDXW'(i);
         end
         if (!valid_q[i] && !free_found) begin
            free_found = 1'b1;
            free_idx   = IDXW'(i);
         end
      end
   end

   always_comb begin
      valid_d   = valid_q;
      tag_d     = tag_q;
      tgt_d     = tgt_q;
      ctr_d     = ctr_q;
      victim_d  = victim_q;
      alloc_idx = free_found ? free_idx : victim_q;
      if (flush) begin
         for (int unsigned i = 0; i < ENTRIES; i++) valid_d[i] = 1'b0;
         victim_d = '0;
      end else if (upd_valid) begin
         if (upd_hit) begin
            if (upd_taken) begin
               tgt_d[upd_idx] = upd_target;
               if (ctr_q[upd_idx] != 2'b11) ctr_d[upd_idx] = ctr_q[upd_idx] + 2'd1;
            end else if (ctr_q[upd_idx] != 2'b00) begin
               ctr_d[upd_idx] = ctr_q[upd_idx] - 2'd1;
            end
         end else if (upd_taken) begin
            valid_d[alloc_idx] = 1'b1;
            tag_d[alloc_idx]   = upd_pc;
            tgt_d[alloc_idx]   = upd_target;
            ctr_d[alloc_idx]   = CTR_INIT;
            // Round-robin only advances when a valid entry had to be evicted.
            if (!free_found) victim_d = victim_q + IDXW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
            tag_q[i]   <= '0;
            tgt_q[i]   <= '0;
            ctr_q[i]   <= '0;
         end
         victim_q <= '0;
      end else begin
         valid_q  <= valid_d;
         tag_q    <= tag_d;
         tgt_q    <= tgt_d;
         ctr_q    <= ctr_d;
         victim_q <= victim_d;
      end
   end

endmodule

// File: tb/tb_btb_2bit_predictor.sv
// Directed bench for btb_2bit_predictor: training, replacement, flush priority,
// same-cycle visibility and asynchronous reset, with hand-computed expectations.
module tb_btb_2bit_predictor;

   localparam int unsigned XLEN = 32;

   logic            clk;
   logic            rstn;
   logic [XLEN-1:0] lookup_pc;
   logic            pred_hit;
   logic            pred_taken;
   logic [XLEN-1:0] pred_target;
   logic            upd_valid;
   logic [XLEN-1:0] upd_pc;
   logic            upd_taken;
   logic [XLEN-1:0] upd_target;
   logic            flush;

   int n_tests;
   int n_fail;

   btb_2bit_predictor #(
      .ENTRIES  (8),
      .XLEN     (XLEN),
      .CTR_INIT (2'b10)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .lookup_pc   (lookup_pc),
      .pred_hit    (pred_hit),
      .pred_taken  (pred_taken),
      .pred_target (pred_target),
      .upd_valid   (upd_valid),
      .upd_pc      (upd_pc),
      .upd_taken   (upd_taken),
      .upd_target  (upd_target),
      .flush       (flush)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic look(input string tag, input logic [XLEN-1:0] pc,
                       input logic hit, input logic tk, input logic [XLEN-1:0] tgt);
      lookup_pc = pc;
      #1;
      check({tag, ".hit"},    XLEN'(pred_hit),   XLEN'(hit));
      check({tag, ".taken"},  XLEN'(pred_taken), XLEN'(tk));
      check({tag, ".target"}, pred_target,       tgt);
   endtask

   task automatic upd(input logic [XLEN-1:0] pc, input logic tk, input logic [XLEN-1:0] tgt);
      @(negedge clk);
      upd_valid  = 1'b1;
      upd_pc     = pc;
      upd_taken  = tk;
      upd_target = tgt;
      @(posedge clk);
      #1;
      upd_valid = 1'b0;
   endtask

   task automatic do_flush();
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
   endtask

   initial begin
      n_tests    = 0;
      n_fail     = 0;
      rstn       = 1'b0;
      lookup_pc  = 32'h100;
      upd_valid  = 1'b0;
      upd_pc     = '0;
      upd_taken  = 1'b0;
      upd_target = '0;
      flush      = 1'b0;

      // Cold state during reset, including +4 wraparound.
      #2;
      look("rst_cold", 32'h100, 1'b0, 1'b0, 32'h104);
      look("rst_wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
      @(posedge clk);
      @(posedge clk);

      // Release reset with an update already presented; it must apply at the first edge.
      @(negedge clk);
      rstn       = 1'b1;
      upd_valid  = 1'b1;
      upd_pc     = 32'h100;
      upd_taken  = 1'b1;
      upd_target = 32'h200;
      look("cold_miss", 32'h100, 1'b0, 1'b0, 32'h104);
      @(posedge clk);
      #1;
      upd_valid = 1'b0;
      look("alloc", 32'h100, 1'b1, 1'b1, 32'h200);

      // Counter training: 10 -> 01 -> 00 -> 00 -> 01 -> 10 -> 11 -> 11 -> 10 -> 01.
      upd(32'h100, 1'b0, 32'h0);
      look("nt1", 32'h100, 1'b1, 1'b0, 32'h104);
      upd(32'h100, 1'b0, 32'h0);
      upd(32'h100, 1'b0, 32'h0);
      upd(32'h100, 1'b1, 32'h280);
      look("sat_lo", 32'h100, 1'b1, 1'b0, 32'h104);
      upd(32'h100, 1'b1, 32'h280);
      look("t_retarget", 32'h100, 1'b1, 1'b1, 32'h280);
      upd(32'h100, 1'b1, 32'h280);
      upd(32'h100, 1'b1, 32'h280);
      upd(32'h100, 1'b0, 32'hDEAD0);
      look("sat_hi_keep_tgt", 32'h100, 1'b1, 1'b1, 32'h280);
      upd(32'h100, 1'b0, 32'h0);
      look("nt_after_sat", 32'h100, 1'b1, 1'b0, 32'h104);
      upd(32'h110, 1'b0, 32'h999);
      look("nt_miss_noalloc", 32'h110, 1'b0, 1'b0, 32'h114);

      do_flush();
      look("flush_clear", 32'h100, 1'b0, 1'b0, 32'h104);

      // Replacement: 9 PCs fill 0..7 then evict entry 0; the 10th evicts entry 1.
      for (int i = 0; i < 9; i++) upd(XLEN'(i * 4), 1'b1, XLEN'(32'h1000 + i * 4));
      look("wrap_evict0", 32'h000, 1'b0, 1'b0, 32'h004);
      look("wrap_new",    32'h020, 1'b1, 1'b1, 32'h1020);
      upd(32'h024, 1'b1, 32'h1024);
      look("evict1",      32'h004, 1'b0, 1'b0, 32'h008);
      look("keep2",       32'h008, 1'b1, 1'b1, 32'h1008);
      look("tenth",       32'h024, 1'b1, 1'b1, 32'h1024);

      // Flush wins over a simultaneous allocation and resets the victim pointer.
      @(negedge clk);
      flush      = 1'b1;
      upd_valid  = 1'b1;
      upd_pc     = 32'h400;
      upd_taken  = 1'b1;
      upd_target = 32'h4F0;
      @(posedge clk);
      #1;
      flush     = 1'b0;
      upd_valid = 1'b0;
      look("flush_prio", 32'h400, 1'b0, 1'b0, 32'h404);
      look("flush_old",  32'h024, 1'b0, 1'b0, 32'h028);
      for (int i = 0; i < 9; i++) upd(XLEN'(32'h500 + i * 4), 1'b1, XLEN'(32'h600 + i * 4));
      look("vict_reset_e0", 32'h500, 1'b0, 1'b0, 32'h504);
      look("vict_reset_e1", 32'h504, 1'b1, 1'b1, 32'h604);
      look("vict_reset_new", 32'h520, 1'b1, 1'b1, 32'h620);

      // No bypass: an update is invisible to lookup in its own cycle.
      @(negedge clk);
      lookup_pc  = 32'h300;
      upd_valid  = 1'b1;
      upd_pc     = 32'h300;
      upd_taken  = 1'b1;
      upd_target = 32'h3A0;
      #1;
      check("same_cycle.hit", XLEN'(pred_hit), 32'h0);
      @(posedge clk);
      #1;
      upd_valid = 1'b0;
      look("next_cycle", 32'h300, 1'b1, 1'b1, 32'h3A0);

      // Asynchronous reset between edges.
      @(posedge clk);
      #2;
      rstn = 1'b0;
      #1;
      check("async_rst.hit", XLEN'(pred_hit), 32'h0);
      check("async_rst.target", pred_target, 32'h304);
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;
      look("post_rst_a", 32'h300, 1'b0, 1'b0, 32'h304);
      look("post_rst_b", 32'h520, 1'b0, 1'b0, 32'h524);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
